// File: rtl/sad_wb_accumulator_if.sv
// Pixel-pair beat stream into the SAD accumulator.
// Handshake: a beat transfers on a rising edge where in_valid && in_ready; cur/ref must be stable while in_valid is high.
interface sad_wb_accumulator_if #(
  parameter int PIX_W = 8,
  parameter int LANES = 4
) ();
  logic                   in_valid;
  logic                   in_ready;
  logic [LANES*PIX_W-1:0] in_cur;
  logic [LANES*PIX_W-1:0] in_ref;

  modport master (output in_valid, output in_cur, output in_ref, input in_ready);
  modport slave  (input in_valid, input in_cur, input in_ref, output in_ready);
endinterface

// File: rtl/sad_wb_accumulator.sv
// SAD window accumulator feeding the register-file write-back slot.
// Optional minimum-SAD tracking is built when SAD_MIN_TRACK_EN is defined.
module sad_wb_accumulator #(
  parameter int PIX_W        = 8,
  parameter int LANES        = 4,
  parameter int BLOCK_PIXELS = 16,
  parameter int ACC_W        = 32
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  start,
  sad_wb_accumulator_if.slave   pix,
  input  logic                  wb_stall,
  output logic                  busy,
  output logic [31:0]           SAD_WB_value,
  output logic                  frame_shift,
  output logic [31:0]           min_sad,
  output logic [15:0]           min_idx,
  output logic [1:0]            state_dbg
);

  localparam int BEATS = (LANES > 0) ? BLOCK_PIXELS / LANES : 1;
  localparam int CNT_W = $clog2(BEATS + 1);
  localparam int SUM_W = PIX_W + $clog2(LANES);
  localparam logic [63:0] MAX_SAD = ((64'd1 << PIX_W) - 64'd1) * 64'(BLOCK_PIXELS);

  if (LANES <= 0 || BLOCK_PIXELS <= 0 || (BLOCK_PIXELS % LANES) != 0) begin : g_bad_block
    $error("BLOCK_PIXELS must be a positive multiple of LANES");
  end
  if (ACC_W < 1 || ACC_W > 32 || (MAX_SAD >> ACC_W) != 64'd0) begin : g_bad_acc
    $error("ACC_W cannot hold the largest window SAD or exceeds the 32-bit result");
  end

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;

  state_t             state;
  logic               ready_q;
  logic [CNT_W-1:0]   beat_cnt;
  logic               s1_valid;
  logic [PIX_W-1:0]   s1_diff [LANES];
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   result;
  logic [SUM_W-1:0]   lane_sum;

  function automatic logic [PIX_W-1:0] abs_diff(input logic [PIX_W-1:0] a, input logic [PIX_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  always_comb begin
    lane_sum = '0;
    for (int i = 0; i < LANES; i++) lane_sum = lane_sum + SUM_W'(s1_diff[i]);
  end

  assign pix.in_ready  = ready_q;
  assign busy          = (state != IDLE);
  assign frame_shift   = (state == DONE) && !wb_stall;
  assign SAD_WB_value  = 32'(result);
  assign state_dbg     = state;

  // ready_q doubles as "beats accepted < BEATS"; its fall marks the extra
  // cycle that lets stage 2 absorb the last beat before DRAIN.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      ready_q  <= 1'b0;
      beat_cnt <= '0;
      s1_valid <= 1'b0;
      acc      <= '0;
      result   <= '0;
      for (int i = 0; i < LANES; i++) s1_diff[i] <= '0;
    end else begin
      s1_valid <= 1'b0;
      if (s1_valid) acc <= acc + ACC_W'(lane_sum);
      case (state)
        IDLE: begin
          if (start) begin
            state    <= ACCUM;
            ready_q  <= 1'b1;
            beat_cnt <= '0;
            acc      <= '0;
          end
        end
        ACCUM: begin
          if (pix.in_valid && ready_q) begin
            for (int i = 0; i < LANES; i++)
              s1_diff[i] <= abs_diff(pix.in_cur[i*PIX_W +: PIX_W], pix.in_ref[i*PIX_W +: PIX_W]);
            s1_valid <= 1'b1;
            beat_cnt <= beat_cnt + 1'b1;
            if (beat_cnt == CNT_W'(BEATS - 1)) ready_q <= 1'b0;
          end else if (!ready_q) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          state  <= DONE;
          result <= acc;
        end
        DONE: begin
          if (!wb_stall) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SAD_MIN_TRACK_EN
  logic [31:0] min_q;
  logic [15:0] idx_q;
  logic [15:0] win_cnt;
  logic        have_min;

  // have_min makes the first window load even if its SAD equals the reset value.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      min_q    <= 32'hFFFF_FFFF;
      idx_q    <= '0;
      win_cnt  <= '0;
      have_min <= 1'b0;
    end else if (frame_shift) begin
      win_cnt <= win_cnt + 16'd1;
      if (!have_min || SAD_WB_value < min_q) begin
        min_q    <= SAD_WB_value;
        idx_q    <= win_cnt;
        have_min <= 1'b1;
      end
    end
  end

  assign min_sad = min_q;
  assign min_idx = idx_q;
`else
  assign min_sad = '0;
  assign min_idx = '0;
`endif

endmodule

// File: tb/tb_sad_wb_accumulator.sv
// Directed bench for sad_wb_accumulator: timing, gaps, stall, abort, ignored start, min tracking.
module tb_sad_wb_accumulator;
  localparam int PIX_W = 8;
  localparam int LANES = 4;
  localparam int LW    = PIX_W * LANES;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        wb_stall = 1'b0;
  logic        busy;
  logic [31:0] sad_value;
  logic        frame_shift;
  logic [31:0] min_sad;
  logic [15:0] min_idx;
  logic [1:0]  state_dbg;

  int vectors = 0;
  int miscompares = 0;

  logic [LW-1:0] beat_cur [4];
  logic [LW-1:0] beat_ref [4];

  always #5 clk = ~clk;

  sad_wb_accumulator_if #(.PIX_W(PIX_W), .LANES(LANES)) pix ();

  sad_wb_accumulator #(.PIX_W(PIX_W), .LANES(LANES), .BLOCK_PIXELS(16), .ACC_W(32)) dut (
    .Clk(clk), .Reset(rst), .start(start), .pix(pix.slave), .wb_stall(wb_stall),
    .busy(busy), .SAD_WB_value(sad_value), .frame_shift(frame_shift),
    .min_sad(min_sad), .min_idx(min_idx), .state_dbg(state_dbg)
  );

  task automatic set_beats(input logic [7:0] c, input logic [7:0] r);
    for (int b = 0; b < 4; b++) begin
      beat_cur[b] = {4{c}};
      beat_ref[b] = {4{r}};
    end
  endtask

  task automatic wait_accept(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (pix.in_ready === 1'b1) begin
        @(posedge clk); #1;
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic run_window(input bit gaps, input int stall_cycles, input bit start_mid,
                            input bit start_fs, input logic [31:0] exp_value);
    bit ok;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    vectors++;
    if (busy !== 1'b1 || pix.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL accum_entry busy=%b ready=%b required 1/1", busy, pix.in_ready);
    end
    for (int b = 0; b < 4; b++) begin
      pix.in_valid = 1'b1;
      pix.in_cur = beat_cur[b];
      pix.in_ref = beat_ref[b];
      if (start_mid && b == 1) start = 1'b1;
      wait_accept(ok);
      start = 1'b0;
      pix.in_valid = 1'b0;
      vectors++;
      if (!ok) begin
        miscompares++;
        $display("FAIL beat_accept beat=%0d not accepted within 20 cycles", b);
      end
      if (gaps && b < 3) repeat (b + 1) begin @(posedge clk); #1; end
    end
    if (stall_cycles > 0) wb_stall = 1'b1;
    vectors++;
    if (pix.in_ready !== 1'b0 || frame_shift !== 1'b0) begin
      miscompares++;
      $display("FAIL last_beat ready=%b fs=%b required 0/0", pix.in_ready, frame_shift);
    end
    @(posedge clk); #1;
    vectors++;
    if (frame_shift !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL drain fs=%b busy=%b required 0/1", frame_shift, busy);
    end
    @(posedge clk); #1;
    vectors++;
    if (sad_value !== exp_value) begin
      miscompares++;
      $display("FAIL result got=%0d required=%0d", sad_value, exp_value);
    end
    for (int s = 0; s < stall_cycles; s++) begin
      vectors++;
      if (frame_shift !== 1'b0 || sad_value !== exp_value) begin
        miscompares++;
        $display("FAIL stall_hold cycle=%0d fs=%b value=%0d required 0/%0d", s, frame_shift, sad_value, exp_value);
      end
      @(posedge clk); #1;
    end
    wb_stall = 1'b0;
    if (start_fs) start = 1'b1;
    #1;
    vectors++;
    if (frame_shift !== 1'b1 || sad_value !== exp_value) begin
      miscompares++;
      $display("FAIL strobe fs=%b value=%0d required 1/%0d", frame_shift, sad_value, exp_value);
    end
    @(posedge clk); #1;
    start = 1'b0;
    vectors++;
    if (frame_shift !== 1'b0 || busy !== 1'b0 || sad_value !== exp_value) begin
      miscompares++;
      $display("FAIL after_strobe fs=%b busy=%b value=%0d required 0/0/%0d", frame_shift, busy, sad_value, exp_value);
    end
    if (start_fs) begin
      repeat (2) begin
        @(posedge clk); #1;
        vectors++;
        if (busy !== 1'b0 || frame_shift !== 1'b0) begin
          miscompares++;
          $display("FAIL start_ignored busy=%b fs=%b required 0/0", busy, frame_shift);
        end
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (sad_value !== 32'd0 || frame_shift !== 1'b0 || busy !== 1'b0 ||
        pix.in_ready !== 1'b0 || state_dbg !== 2'd0) begin
      miscompares++;
      $display("FAIL reset value=%0d fs=%b busy=%b ready=%b state=%0d required all 0",
               sad_value, frame_shift, busy, pix.in_ready, state_dbg);
    end
`ifdef SAD_MIN_TRACK_EN
    vectors++;
    if (min_sad !== 32'hFFFF_FFFF || min_idx !== 16'd0) begin
      miscompares++;
      $display("FAIL reset_min min_sad=%h min_idx=%0d required ffffffff/0", min_sad, min_idx);
    end
`endif
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    set_beats(8'd10, 8'd3);
    run_window(1'b0, 0, 1'b0, 1'b0, 32'd112);
  endtask

  task automatic test_gaps;
    set_beats(8'd0, 8'd255);
    run_window(1'b1, 0, 1'b0, 1'b0, 32'd4080);
  endtask

  task automatic test_stall;
    for (int b = 0; b < 4; b++) begin
      beat_cur[b] = {8'd50, 8'd200, 8'd50, 8'd200};
      beat_ref[b] = {8'd200, 8'd50, 8'd200, 8'd50};
    end
    run_window(1'b0, 5, 1'b0, 1'b0, 32'd2400);
  endtask

  task automatic test_abort;
    bit ok;
    set_beats(8'd255, 8'd0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int b = 0; b < 2; b++) begin
      pix.in_valid = 1'b1;
      pix.in_cur = beat_cur[b];
      pix.in_ref = beat_ref[b];
      wait_accept(ok);
      vectors++;
      if (!ok) begin
        miscompares++;
        $display("FAIL abort_beat beat=%0d not accepted", b);
      end
    end
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if (sad_value !== 32'd0 || frame_shift !== 1'b0 || busy !== 1'b0 || pix.in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset value=%0d fs=%b busy=%b ready=%b required all 0",
               sad_value, frame_shift, busy, pix.in_ready);
    end
    pix.in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      vectors++;
      if (frame_shift !== 1'b0 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL aborted_window fs=%b busy=%b required 0/0", frame_shift, busy);
      end
    end
    set_beats(8'd1, 8'd0);
    run_window(1'b0, 0, 1'b0, 1'b0, 32'd16);
  endtask

  task automatic test_start_ignored;
    set_beats(8'd5, 8'd7);
    run_window(1'b0, 0, 1'b1, 1'b1, 32'd32);
  endtask

  task automatic test_min_track;
    logic [7:0]  sads [4];
    logic [31:0] exp_min [4];
    logic [15:0] exp_idx [4];
    sads = '{8'd100, 8'd50, 8'd70, 8'd50};
    exp_min = '{32'd100, 32'd50, 32'd50, 32'd50};
    exp_idx = '{16'd0, 16'd1, 16'd1, 16'd1};
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    for (int w = 0; w < 4; w++) begin
      set_beats(8'd0, 8'd0);
      beat_cur[0][7:0] = sads[w];
      run_window(1'b0, 0, 1'b0, 1'b0, {24'd0, sads[w]});
      vectors++;
`ifdef SAD_MIN_TRACK_EN
      if (min_sad !== exp_min[w] || min_idx !== exp_idx[w]) begin
        miscompares++;
        $display("FAIL min_track window=%0d min_sad=%0d min_idx=%0d required %0d/%0d",
                 w, min_sad, min_idx, exp_min[w], exp_idx[w]);
      end
`else
      if (min_sad !== 32'd0 || min_idx !== 16'd0) begin
        miscompares++;
        $display("FAIL min_tied window=%0d min_sad=%0d min_idx=%0d required 0/0 (ref %0d)",
                 w, min_sad, min_idx, exp_min[w] + 32'(exp_idx[w]));
      end
`endif
    end
  endtask

  initial begin
    pix.in_valid = 1'b0;
    pix.in_cur = '0;
    pix.in_ref = '0;
    test_reset();
    test_basic();
    test_gaps();
    test_stall();
    test_abort();
    test_start_ignored();
    test_min_track();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end
endmodule
